clock_ratio_meter: RTL

Measures a divided clock against the system clock, which is the receive side of the clock-divider blocks. It samples a slow clock input in the `clk_i` domain and reports the high time, low time and period of every cycle as counts of `clk_i` cycles. It flags when the ratio is stable and when the input has stopped. It is used in bring-up and self-check logic to confirm divider outputs, for example divide-by-6 giving period 6 with a 3/3 duty split.

---
 rtl/clock_ratio_meter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/clock_ratio_meter.sv
// Measures high time, low time and period of a slow clock in clk_i cycles,
// with lock detection on repeated identical measurements and overflow flagging.
module clock_ratio_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clk_div_i,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] low_o,
    output logic [CNT_W:0]   period_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               s, s_d, rise, fall;
    logic [CNT_W-1:0]   high_cnt, low_cnt, ref_high, ref_low;
    logic [MW-1:0]      match_cnt;
    logic               start, inc_high, to_low, inc_low, publish, overflow, clear;
    logic               pair_match;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q[0] <= clk_div_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d <= s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Enable low takes priority over everything, so no pulses escape while disabled.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        inc_high = 1'b0;
        to_low   = 1'b0;
        inc_low  = 1'b0;
        publish  = 1'b0;
        overflow = 1'b0;
        clear    = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        start   = 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        to_low  = 1'b1;
                    end else if (s) begin
                        if (high_cnt == CNT_MAX) begin
                            overflow = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            inc_high = 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        publish = 1'b1;
                        state_d = HIGH;
                    end else if (!s) begin
                        if (low_cnt == CNT_MAX) begin
                            overflow = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            inc_low = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // match_cnt of zero marks an empty reference after IDLE.
    assign pair_match = (match_cnt != '0) && (high_cnt == ref_high) && (low_cnt == ref_low);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            high_cnt  <= '0;
            low_cnt   <= '0;
            ref_high  <= '0;
            ref_low   <= '0;
            match_cnt <= '0;
            high_o    <= '0;
            low_o     <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            valid_o <= publish;
            err_o   <= overflow;
            if (clear || overflow) begin
                high_cnt  <= '0;
                low_cnt   <= '0;
                match_cnt <= '0;
                locked_o  <= 1'b0;
            end else begin
                if (start)    high_cnt <= CNT_W'(1);
                if (inc_high) high_cnt <= high_cnt + CNT_W'(1);
                if (to_low)   low_cnt  <= CNT_W'(1);
                if (inc_low)  low_cnt  <= low_cnt + CNT_W'(1);
                if (publish) begin
                    high_o   <= high_cnt;
                    low_o    <= low_cnt;
                    period_o <= {1'b0, high_cnt} + {1'b0, low_cnt};
                    high_cnt <= CNT_W'(1);
                    low_cnt  <= '0;
                    if (pair_match) begin
                        if (match_cnt != MW'(LOCK_COUNT)) match_cnt <= match_cnt + MW'(1);
                        if (match_cnt >= MW'(LOCK_COUNT - 1)) locked_o <= 1'b1;
                    end else begin
                        ref_high  <= high_cnt;
                        ref_low   <= low_cnt;
                        match_cnt <= MW'(1);
                        locked_o  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
